// File: rtl/uart_tx_scheduler.sv
// Purpose : round-robin reporter of demod level changes as status bytes to one shared UART transmitter.
// Latency : demod change visible after 2 sync cycles; byte issued on the next rate tick (tx_start registered).
// Backpr. : busy gates issue; busy must rise within BUSY_TO cycles or the change is re-armed and to_err pulses.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   demod    asynchronous demodulator levels, one bit per channel
//   busy     transmitter busy, high while a byte is shifted out
//   tx_start one-cycle load request to the transmitter
//   tx_data  status byte {channel[3:0], 3'b000, level}, held until the next grant
//   to_err   one-cycle pulse when busy fails to rise after tx_start
//   rr_ptr   round-robin search start channel (debug)

module uart_tx_scheduler #(
  parameter int NUM_CH   = 2,
  parameter int TICK_DIV = 5000,
  parameter int BUSY_TO  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] demod,
  input  logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              to_err,
  output logic [3:0]        rr_ptr
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(BUSY_TO + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] TO_MAX   = OW'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [NUM_CH-1:0] s1_q, s2_q;
  logic [NUM_CH-1:0] mem_q, mem_d;
  logic              prev_q, prev_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [OW-1:0]     to_cnt_q, to_cnt_d;
  logic [3:0]        rr_q, rr_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              to_err_q, to_err_d;

  logic              tick;
  logic [NUM_CH-1:0] pending;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     srch_idx;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // A change is pending only while the synchronized level differs from the
  // last reported one, so a glitch that reverts before service is dropped.
  assign pending = s2_q ^ mem_q;

  // First pending channel starting at rr_q, wrapping modulo NUM_CH.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    srch_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      srch_idx = IW'((int'(rr_q) + k) % NUM_CH);
      if (!gnt_vld && pending[srch_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = srch_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    prev_d     = prev_q;
    gnt_d      = gnt_q;
    to_cnt_d   = to_cnt_q;
    rr_d       = rr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    to_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // gnt_vld already implies at least one channel is pending.
        if (tick && gnt_vld && !busy) begin
          tx_start_d     = 1'b1;
          tx_data_d      = {4'(gnt_idx), 3'b000, s2_q[gnt_idx]};
          mem_d[gnt_idx] = s2_q[gnt_idx];
          prev_d         = mem_q[gnt_idx];
          gnt_d          = gnt_idx;
          rr_d           = 4'((int'(gnt_idx) + 1) % NUM_CH);
          to_cnt_d       = '0;
          state_d        = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_MAX) begin
          // Transmitter never took the byte: restore the old reported level
          // so the change is pending again; rr_q keeps its advanced value.
          mem_d[gnt_q] = prev_q;
          to_err_d     = 1'b1;
          state_d      = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      mem_q      <= '0;
      prev_q     <= 1'b0;
      gnt_q      <= '0;
      to_cnt_q   <= '0;
      rr_q       <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      s1_q       <= demod;
      s2_q       <= s1_q;
      mem_q      <= mem_d;
      prev_q     <= prev_d;
      gnt_q      <= gnt_d;
      to_cnt_q   <= to_cnt_d;
      rr_q       <= rr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      to_err_q   <= to_err_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign to_err   = to_err_q;
  assign rr_ptr   = rr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose : scoreboard bench for uart_tx_scheduler with a behavioural busy responder.
// Latency : expected bytes queued by stimulus, popped by a negedge monitor on each tx_start.
// Backpr. : busy responder is switchable (normal / never responds) with programmable hold length.

module tb_uart_tx_scheduler;

  localparam int NUM_CH   = 2;
  localparam int TICK_DIV = 20;
  localparam int BUSY_TO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] demod = 2'b00;
  logic       busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       to_err;
  logic [3:0] rr_ptr;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_CH  (NUM_CH),
    .TICK_DIV(TICK_DIV),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .demod   (demod),
    .busy    (busy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .to_err  (to_err),
    .rr_ptr  (rr_ptr)
  );

  int         n_checks = 0;
  int         n_errs   = 0;
  logic [7:0] exp_tx[$];
  int         exp_err[$];
  int         cyc        = 0;
  int         last_start = 0;
  bit         have_prev  = 1'b0;
  logic [7:0] last_data  = 8'h00;
  bit         mon_en     = 1'b0;
  int         err_seen   = 0;
  bit         busy_en    = 1'b1;
  int         busy_len   = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_checks++;
    n_errs++;
    $display("FAIL %s: observed %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Transmitter model: sees tx_start just after the edge that raised it and
  // holds busy for busy_len cycles, unless switched off.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_start && busy_en) begin
        busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (tx_start) begin
        if (exp_tx.size() == 0) flag("unexpected_tx_start", 32'(tx_data));
        else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        if (have_prev) check("one_byte_per_tick", 32'(cyc - last_start >= TICK_DIV), 32'd1);
        last_start = cyc;
        have_prev  = 1'b1;
        last_data  = tx_data;
      end else begin
        check("tx_data_hold", 32'(tx_data), 32'(last_data));
      end
      if (to_err) begin
        if (exp_err.size() == 0) flag("unexpected_to_err", 32'(cyc - last_start));
        else check("to_err_delay", 32'(cyc - last_start), 32'(exp_err.pop_front()));
        err_seen++;
      end
    end
    if (rst) begin
      have_prev = 1'b0;
      last_data = 8'h00;
    end
  end

  task automatic drive(input logic [1:0] v);
    @(posedge clk);
    #1;
    demod = v;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_tx.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'h00);
    check({tag, "_to_err"},   32'(to_err),   32'd0);
    check({tag, "_rr_ptr"},   32'(rr_ptr),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Quiet inputs: nothing may be sent
    settle(100);
    check("idle_rr_ptr", 32'(rr_ptr), 32'd0);

    // Single change on channel 1
    exp_tx.push_back(8'h11);
    drive(2'b10);
    drain("p1_drain", 100);
    settle(130);
    check("p1_rr_ptr", 32'(rr_ptr), 32'd0);

    // Channel 1 back to 0
    exp_tx.push_back(8'h10);
    drive(2'b00);
    drain("p2_drain", 100);
    settle(130);

    // 3-cycle glitch on channel 0 placed well clear of the next tick
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (((cyc - last_start) % TICK_DIV) != 2 && n < 60);
    #1;
    demod = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    demod = 2'b00;
    settle(60);
    check("glitch_rr_ptr", 32'(rr_ptr), 32'd0);

    // Both channels together, short busy: one byte per tick, ch0 first
    busy_len = 3;
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h11);
    drive(2'b11);
    drain("p4_drain", 200);
    settle(30);
    check("p4_rr_ptr", 32'(rr_ptr), 32'd0);

    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h10);
    drive(2'b00);
    drain("p4b_drain", 200);
    settle(30);
    check("p4b_rr_ptr", 32'(rr_ptr), 32'd0);

    // Transmitter never answers: to_err, then same byte retried on next tick
    busy_en = 1'b0;
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h01);
    exp_err.push_back(BUSY_TO);
    e0 = err_seen;
    drive(2'b01);
    n = 0;
    while (err_seen == e0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("p5_to_err_seen", 32'(err_seen - e0), 32'd1);
    #1;
    busy_en = 1'b1;
    drain("p5_drain", 100);
    settle(30);
    check("p5_rr_ptr", 32'(rr_ptr), 32'd1);

    // Reset while WAIT_DONE with busy high
    busy_len = 100;
    exp_tx.push_back(8'h11);
    drive(2'b11);
    drain("p6_pre_drain", 100);
    settle(10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h11);
    drain("p6_drain", 400);
    settle(130);
    check("p6_rr_ptr", 32'(rr_ptr), 32'd0);

    check("to_err_all_seen", 32'(exp_err.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmitter among NUM_CH demodulator status lines. It detects level changes on each channel and reports each change as one status byte to the transmitter. Channels are served round-robin, and the transmitter's busy signal is used as the handshake. New transmissions are issued only on an internal rate tick, which caps the UART message rate independently of input activity.

Parameters:
NUM_CH, 2, number of demod input channels (1..16)
TICK_DIV, 5000, clk cycles per scheduling tick (100 MHz / 5000 = 20 kHz)
BUSY_TO, 16, clk cycles to wait for busy to rise after tx_start before abandoning the attempt

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
demod  input  NUM_CH  asynchronous demodulator levels, one per channel
busy  input  1  UART transmitter busy; high while a byte is being shifted out
tx_start  output  1  one-cycle request to the transmitter to load tx_data
tx_data  output  8  status byte: [7:4] channel index, [3:1] 3'b000, [0] reported level
to_err  output  1  one-cycle pulse when busy fails to rise within BUSY_TO cycles
rr_ptr  output  4  current round-robin start channel (debug)

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high, and applies on any clk edge, including mid-transfer.
- Reset values: tx_start=0, tx_data=8'h00, to_err=0, rr_ptr=0, FSM=IDLE, tick counter=0, sync flops=0, reported-level register mem=0.
- Synchronizer: demod passes through 2 flops per bit (s1, s2). All decisions use s2. Input-to-visible latency is 2 cycles.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 only in the cycle where counter==TICK_DIV-1.
- Pending (combinational): pending[i] = s2[i] != mem[i].
  - No separate pending flag is stored.
  - A pulse that returns to its reported level before service is never sent.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Issue condition: tick=1 and |pending and busy=0.
  - Grant g = first i with pending[i], searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_CH.
  - In the issue cycle (registered, visible next cycle): tx_start<=1, tx_data<={g[3:0],3'b000,s2[g]}, mem[g]<=s2[g], prev<=mem[g], rr_ptr<=(g+1) mod NUM_CH, go to WAIT_BUSY with its timeout counter cleared.
  - Otherwise stay in IDLE.
- tx_start: high for exactly one cycle per grant. tx_data is held stable from tx_start until the next grant.
- WAIT_BUSY:
  - busy=1: go to WAIT_DONE.
  - busy=0: increment the timeout counter.
  - On the BUSY_TO-th cycle without busy: restore mem[g]<=prev so the change is re-pending, pulse to_err, return to IDLE. rr_ptr keeps its advanced value.
- WAIT_DONE: stay while busy=1. On busy=0 go to IDLE. The next grant waits for the next tick, so there is at most one byte per tick.
- If busy is already high in IDLE, issuing is suppressed. A tick missed for this reason is not remembered.
- Simultaneous events:
  - If channel g changes in the same cycle it is granted, the pre-change s2 value is reported. The new value appears as pending afterwards and is sent on a later tick.
  - Changes on other channels during a transfer remain pending and are served in round-robin order.
- Fairness: a channel that toggles continuously cannot starve the others. Each grant moves rr_ptr past the served channel.
- NUM_CH=1: rr_ptr stays 0 and the block degenerates to a change-reporter.
- Reset during WAIT_BUSY or WAIT_DONE: the FSM returns to IDLE immediately and no tx_start is issued in the reset cycle. After reset, mem=0, so any channel with s2=1 is pending.

Test Plan:
- Reset, demod=2'b00, busy model responds 1 cycle after tx_start and holds busy 100 cycles -> tx_start never asserts. to_err=0. rr_ptr=0.
- demod[1] 0->1, then wait for tick -> one tx_start with tx_data=8'h11. After busy falls, no further tx_start. rr_ptr=0.
- demod=2'b11 set together -> first tick sends 8'h01 (ch0), a later tick sends 8'h11 (ch1). Exactly one byte per tick.
- demod[0] pulses high for 3 cycles entirely between ticks -> no transmission.
- Busy model never responds -> to_err pulses BUSY_TO cycles after tx_start. The same byte (8'h01) is retried on the next tick.
- Assert rst in WAIT_DONE with busy=1 -> all outputs return to reset values next cycle. With demod[0] held at 1, 8'h01 is sent on the first tick after reset once busy is low.
